// File: rtl/mem_access_pkg.sv
// Shared types and decode helpers for the MEM-stage data-memory access controller.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Store enable takes priority; an illegal store size suppresses the access even if a load is also flagged.
  function automatic logic op_valid(input logic [3:0] rd, input logic [2:0] wr);
    logic v;
    v = 1'b0;
    if (wr[2]) begin
      v = (wr[1:0] != 2'b11);
    end else if (rd[3]) begin
      case (rd[2:0])
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: v = 1'b1;
        default:                             v = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    logic ok;
    case (size)
      SZ_H:    ok = (a[0] == 1'b0);
      SZ_W:    ok = (a == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << a;
      SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane selection and sign/zero extension of the returned memory word.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = 32'd0;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_rdata;
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: turns RV32 loads/stores into word-aligned, byte-enabled
// req/ack transactions, stalling the pipeline until each access completes.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_read_in,
  input  logic [2:0]  mem_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic        pipe_hold_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] load_data_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic        r_misaligned;
  logic        r_bus_err;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;

  logic        w_valid;
  logic        w_is_store;
  logic [1:0]  w_size;
  logic        w_aligned;
  logic [31:0] w_wdata;
  logic        w_timeout;
  logic        w_stall;
  logic [31:0] w_ext;

  assign w_valid    = op_valid(mem_read_in, mem_write_in);
  assign w_is_store = mem_write_in[2];
  assign w_size     = w_is_store ? mem_write_in[1:0] : mem_read_in[1:0];
  assign w_aligned  = is_aligned(w_size, addr_in[1:0]);
  // An ack in the final wait cycle takes precedence over the timeout.
  assign w_timeout  = (r_cnt == CNT_LAST) && !dmem_ack;

  always_comb begin
    case (w_size)
      SZ_B:    w_wdata = {4{store_data_in[7:0]}};
      SZ_H:    w_wdata = {2{store_data_in[15:0]}};
      default: w_wdata = store_data_in;
    endcase
  end

  load_extend u_load_extend (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (r_lane),
    .i_funct3  (r_funct3),
    .o_data    (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_stall      = 1'b1;
          w_state_next = w_aligned ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        w_stall = 1'b1;
        if (dmem_ack || w_timeout) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!pipe_hold_in) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= 16'd0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_be         <= 4'd0;
      r_wdata      <= 32'd0;
      r_load_data  <= 32'd0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_is_load    <= 1'b0;
      r_funct3     <= 3'd0;
      r_lane       <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            if (w_aligned) begin
              r_req     <= 1'b1;
              r_we      <= w_is_store;
              r_addr    <= {addr_in[31:2], 2'b00};
              r_be      <= lane_be(w_size, addr_in[1:0]);
              r_wdata   <= w_wdata;
              r_is_load <= !w_is_store;
              r_funct3  <= mem_read_in[2:0];
              r_lane    <= addr_in[1:0];
              r_cnt     <= 16'd0;
            end else begin
              r_misaligned <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 16'd1;
          if (dmem_ack) begin
            r_req <= 1'b0;
            if (r_is_load) r_load_data <= w_ext;
          end else if (w_timeout) begin
            r_req       <= 1'b0;
            r_bus_err   <= 1'b1;
            r_load_data <= 32'd0;
          end
        end
        ST_DONE: begin
          if (!pipe_hold_in) begin
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req       = r_req;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_be        = r_be;
  assign dmem_wdata     = r_wdata;
  assign load_data_out  = r_load_data;
  assign misaligned_out = r_misaligned;
  assign bus_err_out    = r_bus_err;
  assign stall_out      = w_stall && !rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed expectations checked by immediate assertions.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  mem_read_in;
  logic [2:0]  mem_write_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        pipe_hold_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] load_data_out;
  logic        stall_out;
  logic        misaligned_out;
  logic        bus_err_out;

  int total;
  int bad;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .addr_in        (addr_in),
    .store_data_in  (store_data_in),
    .pipe_hold_in   (pipe_hold_in),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .load_data_out  (load_data_out),
    .stall_out      (stall_out),
    .misaligned_out (misaligned_out),
    .bus_err_out    (bus_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_in   = 4'd0;
    mem_write_in  = 3'd0;
    addr_in       = 32'd0;
    store_data_in = 32'd0;
    dmem_ack      = 1'b0;
    dmem_rdata    = 32'd0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    pipe_hold_in = 1'b0;
    idle_inputs();
    rst = 1'b1;
    mem_write_in = 3'b110;
    addr_in = 32'h100;
    #12;
    chk("rst_stall_forced", {31'd0, stall_out}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_load_data", load_data_out, 32'd0);
    chk("rst_flags", {30'd0, misaligned_out, bus_err_out}, 32'd0);
    chk("rst_addr_be", {dmem_addr[27:0], dmem_be}, 32'd0);
    idle_inputs();
    rst = 1'b0;
    tick();

    // non-memory op: no stall
    chk("nop_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("nop_req", {31'd0, dmem_req}, 32'd0);

    // SW 0x100 0xDEADBEEF, ack next cycle
    mem_write_in = 3'b110; addr_in = 32'h100; store_data_in = 32'hDEADBEEF;
    #1;
    chk("sw_stall_c0", {31'd0, stall_out}, 32'd1);
    tick();
    chk("sw_req", {31'd0, dmem_req}, 32'd1);
    chk("sw_we", {31'd0, dmem_we}, 32'd1);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_be", {28'd0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall_c1", {31'd0, stall_out}, 32'd1);
    dmem_ack = 1'b1;
    tick();
    idle_inputs();
    #1;
    chk("sw_done_req", {31'd0, dmem_req}, 32'd0);
    chk("sw_done_stall", {31'd0, stall_out}, 32'd0);
    tick();

    // LB 0x203, rdata 0x80FFFFFF
    mem_read_in = 4'b1000; addr_in = 32'h203;
    tick();
    chk("lb_addr", dmem_addr, 32'h200);
    chk("lb_be", {28'd0, dmem_be}, 32'h8);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FFFFFF;
    tick();
    idle_inputs();
    chk("lb_data", load_data_out, 32'hFFFFFF80);
    tick();

    // LBU 0x203, ack late (k=3)
    mem_read_in = 4'b1100; addr_in = 32'h203;
    tick();
    tick();
    chk("lbu_req_held", {31'd0, dmem_req}, 32'd1);
    chk("lbu_addr_stable", dmem_addr, 32'h200);
    chk("lbu_stall_wait", {31'd0, stall_out}, 32'd1);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h80FFFFFF;
    tick();
    idle_inputs();
    chk("lbu_data", load_data_out, 32'h00000080);
    tick();

    // SH 0x32 0x0000ABCD
    mem_write_in = 3'b101; addr_in = 32'h32; store_data_in = 32'h0000ABCD;
    tick();
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_addr", dmem_addr, 32'h30);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    idle_inputs();
    chk("sh_keeps_load_data", load_data_out, 32'h00000080);
    tick();

    // SB 0x41 0x000000A5: lane 1
    mem_write_in = 3'b100; addr_in = 32'h41; store_data_in = 32'h000000A5;
    tick();
    chk("sb_be", {28'd0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    dmem_ack = 1'b1;
    tick();
    idle_inputs();
    tick();

    // LW 0x41 misaligned, with a pipe hold in DONE
    mem_read_in = 4'b1010; addr_in = 32'h41;
    #1;
    chk("mis_stall_c0", {31'd0, stall_out}, 32'd1);
    tick();
    chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_flag", {31'd0, misaligned_out}, 32'd1);
    chk("mis_done_stall", {31'd0, stall_out}, 32'd0);
    pipe_hold_in = 1'b1;
    tick();
    chk("mis_flag_held", {31'd0, misaligned_out}, 32'd1);
    pipe_hold_in = 1'b0;
    idle_inputs();
    tick();
    chk("mis_flag_clear", {31'd0, misaligned_out}, 32'd0);

    // LH 0x06 sign-extended upper half
    mem_read_in = 4'b1001; addr_in = 32'h06;
    tick();
    chk("lh_be", {28'd0, dmem_be}, 32'hC);
    dmem_ack = 1'b1; dmem_rdata = 32'h80011234;
    tick();
    idle_inputs();
    chk("lh_data", load_data_out, 32'hFFFF8001);
    tick();

    // illegal encodings and a stray ack in IDLE
    mem_read_in = 4'b1011; addr_in = 32'h10; dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
    #1;
    chk("ill_load_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("ill_load_req", {31'd0, dmem_req}, 32'd0);
    chk("stray_ack_data", load_data_out, 32'hFFFF8001);
    mem_read_in = 4'b1010; mem_write_in = 3'b111; dmem_ack = 1'b0;
    #1;
    chk("ill_store_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("ill_store_req", {31'd0, dmem_req}, 32'd0);
    idle_inputs();
    tick();

    // LW 0x80 never acked: timeout after 4 ACCESS cycles
    mem_read_in = 4'b1010; addr_in = 32'h80;
    tick();
    tick();
    tick();
    tick();
    chk("to_req_last_wait", {31'd0, dmem_req}, 32'd1);
    tick();
    chk("to_bus_err", {31'd0, bus_err_out}, 32'd1);
    chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("to_load_zero", load_data_out, 32'd0);
    chk("to_stall", {31'd0, stall_out}, 32'd0);
    idle_inputs();
    tick();
    chk("to_err_clear", {31'd0, bus_err_out}, 32'd0);

    // LW 0x84 acked in the timeout cycle: ack wins
    mem_read_in = 4'b1010; addr_in = 32'h84;
    tick();
    tick();
    tick();
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
    tick();
    idle_inputs();
    chk("ack_wins_err", {31'd0, bus_err_out}, 32'd0);
    chk("ack_wins_data", load_data_out, 32'h11223344);
    tick();

    // reset during ACCESS, then a normal LW
    mem_read_in = 4'b1010; addr_in = 32'h90;
    tick();
    chk("rmid_req_before", {31'd0, dmem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid_req", {31'd0, dmem_req}, 32'd0);
    chk("rmid_stall", {31'd0, stall_out}, 32'd0);
    chk("rmid_load_data", load_data_out, 32'd0);
    #2;
    rst = 1'b0;
    idle_inputs();
    tick();
    mem_read_in = 4'b1010; addr_in = 32'hA0;
    tick();
    chk("post_rst_addr", dmem_addr, 32'hA0);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    idle_inputs();
    chk("post_rst_data", load_data_out, 32'hCAFEF00D);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
